// File: rtl/sm_pkg.sv
// Shared state encoding and default widths for the
// sign-magnitude accumulator slice.
package sm_pkg;

  localparam int MAG_W_DEF = 20;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

endpackage

// File: rtl/sm_add.sv
// Combinational sign-magnitude adder with magnitude
// saturation and +0 normalisation of inputs and result.
module sm_add
  import sm_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic [MAG_W:0] a,
  input  logic [MAG_W:0] b,
  output logic [MAG_W:0] sum,
  output logic           ovf
);

  logic [MAG_W-1:0] w_ma;
  logic [MAG_W-1:0] w_mb;
  logic             w_sa;
  logic             w_sb;
  logic [MAG_W:0]   w_add;
  logic [MAG_W-1:0] w_mag;
  logic             w_sign;

  always_comb begin
    w_ma   = a[MAG_W-1:0];
    w_mb   = b[MAG_W-1:0];
    w_sa   = a[MAG_W] & (|w_ma);
    w_sb   = b[MAG_W] & (|w_mb);
    w_add  = {1'b0, w_ma} + {1'b0, w_mb};
    ovf    = 1'b0;
    w_mag  = '0;
    w_sign = 1'b0;
    unique case (1'b1)
      (w_sa == w_sb): begin
        ovf    = w_add[MAG_W];
        w_mag  = ovf ? '1 : w_add[MAG_W-1:0];
        w_sign = w_sa;
      end
      (w_sa != w_sb) && (w_ma >= w_mb): begin
        w_mag  = w_ma - w_mb;
        w_sign = w_sa;
      end
      default: begin
        w_mag  = w_mb - w_ma;
        w_sign = w_sb;
      end
    endcase
    // a zero magnitude always leaves with sign 0
    sum = {w_sign & (|w_mag), w_mag};
  end

endmodule

// File: rtl/sm_accumulator.sv
// Sign-magnitude streaming accumulator: sums terms up to
// in_last, then holds the result until the consumer takes it.
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  state_t           r_state;
  logic [MAG_W:0]   r_acc;
  logic             r_sat;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [MAG_W:0]   w_acc_nxt;
  logic             w_sat_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [MAG_W:0]   w_sum;
  logic             w_ovf;
  logic [MAG_W:0]   w_term;
  logic             w_take;

  sm_add #(.MAG_W(MAG_W)) u_add (
    .a   (r_acc),
    .b   (in_data),
    .sum (w_sum),
    .ovf (w_ovf)
  );

  assign w_term = {in_data[MAG_W] & (|in_data[MAG_W-1:0]),
                   in_data[MAG_W-1:0]};
  assign w_take = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_sat_nxt   = r_sat;
    w_cnt_nxt   = r_cnt;
    if (clr) begin
      w_state_nxt = S_ACC;
      w_acc_nxt   = '0;
      w_sat_nxt   = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_ACC: begin
          if (w_take) begin
            // counter never wraps, so zero marks the first term
            if (r_cnt == '0) begin
              w_acc_nxt = w_term;
            end else begin
              w_acc_nxt = w_sum;
              w_sat_nxt = r_sat | w_ovf;
            end
            if (r_cnt != '1) begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            if (in_last) begin
              w_state_nxt = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            w_state_nxt = S_ACC;
            w_acc_nxt   = '0;
            w_sat_nxt   = 1'b0;
            w_cnt_nxt   = '0;
          end
        end
        default: w_state_nxt = S_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACC;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_sat   <= w_sat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_OUT);
  assign out_data  = r_acc;
  assign out_sat   = r_sat;
  assign out_count = r_cnt;

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed bench for sm_accumulator with MAG_W=20, CNT_W=8.
module tb_sm_accumulator;

  localparam int MAG_W = 20;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [MAG_W:0]   in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W:0]   out_data;
  logic             out_sat;
  logic [CNT_W-1:0] out_count;

  int checks;
  int failures;
  logic [MAG_W:0] held;

  sm_accumulator #(.MAG_W(MAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [MAG_W:0] sm(input logic neg,
                                        input int unsigned mag);
    logic [MAG_W-1:0] m;
    m = mag[MAG_W-1:0];
    return {neg, m};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic term(input logic [MAG_W:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_res(input string tag,
                         input logic [MAG_W:0] d,
                         input int c,
                         input logic s);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_cnt"}, 32'(out_count), 32'(c));
    chk({tag, "_sat"}, 32'(out_sat), 32'(s));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    chk({tag, "_cnt0"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    term(sm(0, 5), 1'b0);
    term(sm(1, 3), 1'b0);
    term(sm(0, 10), 1'b1);
    chk_res("mix", 21'h00000C, 3, 1'b0);
    drain("mix");

    term(sm(0, 7), 1'b0);
    term(sm(1, 7), 1'b1);
    chk_res("cancel", 21'h000000, 2, 1'b0);
    drain("cancel");

    term(sm(0, 3), 1'b0);
    term(sm(1, 8), 1'b1);
    chk_res("neg", 21'h100005, 2, 1'b0);
    drain("neg");

    term(sm(1, 0), 1'b0);
    term(sm(1, 4), 1'b1);
    chk_res("negzero", 21'h100004, 2, 1'b0);
    drain("negzero");

    term(sm(1, 0), 1'b1);
    chk_res("single_nz", 21'h000000, 1, 1'b0);
    drain("single_nz");

    term(sm(0, 20'hFFFFF), 1'b0);
    term(sm(0, 1), 1'b0);
    term(sm(1, 20'h10), 1'b1);
    chk_res("sat", 21'h0FFFEF, 3, 1'b1);

    held = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", 32'(out_data), 32'(held));
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_vld", 32'(out_valid), 32'd1);
    end
    chk("bp_sat_held", 32'(out_sat), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = sm(0, 9);
    in_last   = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    chk("bp_release_vld", 32'(out_valid), 32'd0);
    chk("bp_release_sat", 32'(out_sat), 32'd0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_res("bp_next", 21'h000009, 1, 1'b0);
    drain("bp_next");

    for (int i = 0; i < 300; i++) begin
      term(sm(0, 1), (i == 299));
    end
    chk_res("cnt_sat", 21'h00012C, 255, 1'b0);
    drain("cnt_sat");

    term(sm(0, 4), 1'b0);
    term(sm(0, 4), 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = sm(0, 100);
    in_last  = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("clr_vld", 32'(out_valid), 32'd0);
    chk("clr_cnt", 32'(out_count), 32'd0);
    chk("clr_data", 32'(out_data), 32'd0);
    term(sm(0, 1), 1'b1);
    chk_res("clr", 21'h000001, 1, 1'b0);

    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd1);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_cnt", 32'(out_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    term(sm(1, 6), 1'b1);
    chk_res("post_rst", 21'h100006, 1, 1'b0);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
